seq_magnitude_comparator: RTL

//   Multi-cycle WIDTH-bit magnitude comparator for the calculator datapath.

---
 rtl/seq_magnitude_comparator_pkg.sv | 28 ++
 rtl/seq_magnitude_comparator_cmp_chunk.sv | 19 +
 rtl/seq_magnitude_comparator.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// Shared types and helpers for the sequential magnitude comparator.
// FSM state encoding, result codes and an index-width helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] CMP_EQ = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;
  localparam logic [1:0] CMP_GT = 2'd2;

  // Bits needed to hold an index 0..value-1; never less than one bit.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_magnitude_comparator_cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-bit slice of each operand.
module cmp_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  output logic             c_eq,
  output logic             c_lt,
  output logic             c_gt
);

  // Plain unsigned relation of the two slices.
  always_comb begin
    c_eq = (a_i == b_i);
    c_lt = (a_i <  b_i);
    c_gt = (a_i >  b_i);
  end

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator: walks CHUNK-bit slices from the
// MSB end and stops at the first unequal slice. Signed compares flip the sign
// bit of both operands so the slice walk stays purely unsigned.
// Optional feature macro: MINMAX_OUT_EN adds min_o/max_o carrying the
// original operands ordered by the compare result.
module seq_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             lt,
  output logic             gt
`ifdef MINMAX_OUT_EN
  ,
  output logic [WIDTH-1:0] min_o,
  output logic [WIDTH-1:0] max_o
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = clog2(NCHUNK);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  if (CHUNK < 1 || CHUNK > WIDTH) begin : g_chunk_range
    $error("seq_magnitude_comparator: CHUNK must be in 1..WIDTH");
  end else if (WIDTH % CHUNK != 0) begin : g_chunk_mult
    $error("seq_magnitude_comparator: WIDTH must be a multiple of CHUNK");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sgn_q;
  logic [WIDTH-1:0] a_cmp, b_cmp;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic             c_eq, c_lt, c_gt;
  logic             chunk_done;
  logic [1:0]       res_code;
  logic             accept;

  assign accept = in_valid && (state_q == IDLE);

  // Capture operands once per accepted request; held untouched until next accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q   <= a;
      b_q   <= b;
      sgn_q <= signed_mode;
    end
  end

  // Sign-bit flip maps two's-complement order onto unsigned order; select current slice.
  always_comb begin
    a_cmp   = a_q ^ (sgn_q ? MSB_MASK : '0);
    b_cmp   = b_q ^ (sgn_q ? MSB_MASK : '0);
    a_chunk = a_cmp[int'(idx_q)*CHUNK +: CHUNK];
    b_chunk = b_cmp[int'(idx_q)*CHUNK +: CHUNK];
  end

  cmp_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a_i (a_chunk),
    .b_i (b_chunk),
    .c_eq(c_eq),
    .c_lt(c_lt),
    .c_gt(c_gt)
  );

  // Result of the slice under test; the walk ends on inequality or at slice 0.
  always_comb begin
    chunk_done = !c_eq || (idx_q == '0);
    if (c_gt)      res_code = CMP_GT;
    else if (c_lt) res_code = CMP_LT;
    else           res_code = CMP_EQ;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)   state_d = RUN;
      RUN:     if (chunk_done) state_d = DONE;
      DONE:    if (out_ready)  state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Slice index and result flags next values.
  always_comb begin
    idx_d = idx_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    gt_d  = gt_q;
    case (state_q)
      IDLE: if (in_valid) idx_d = IDX_LAST;
      RUN: begin
        if (chunk_done) begin
          eq_d = (res_code == CMP_EQ);
          lt_d = (res_code == CMP_LT);
          gt_d = (res_code == CMP_GT);
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          eq_d = 1'b0;
          lt_d = 1'b0;
          gt_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Slice index and result flag registers; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      eq_q  <= 1'b0;
      lt_q  <= 1'b0;
      gt_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      eq_q  <= eq_d;
      lt_q  <= lt_d;
      gt_q  <= gt_d;
    end
  end

  assign eq = eq_q;
  assign lt = lt_q;
  assign gt = gt_q;

`ifdef MINMAX_OUT_EN
  logic [WIDTH-1:0] min_q, min_d, max_q, max_d;

  // Order the original operands by the final result; cleared when consumed.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (state_q == RUN && chunk_done) begin
      case (res_code)
        CMP_GT:  begin min_d = b_q; max_d = a_q; end
        CMP_LT:  begin min_d = a_q; max_d = b_q; end
        default: begin min_d = a_q; max_d = a_q; end
      endcase
    end else if (state_q == DONE && out_ready) begin
      min_d = '0;
      max_d = '0;
    end
  end

  // Min/max result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_q <= '0;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
`endif

endmodule
